div32_seq: RTL and testbench

Sequential unsigned 32-bit restoring divider for the ALU32 datapath. It accepts a dividend and divisor on a start pulse and runs one quotient bit per clock through a single ripple subtractor. It returns the quotient, the remainder and a divide-by-zero flag with a one-cycle done pulse. It sits directly downstream of the operand registers and consumes the team's parameterised subtractor, `sub32_gen`, as its only arithmetic element.

---
 rtl/div32_seq_pkg.sv | 16 +
 rtl/sub32_gen.sv | 12 +
 rtl/div32_seq.sv | 107 ++++++++++
 tb/tb_div32_seq.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/div32_seq_pkg.sv
// rtl/div32_seq_pkg.sv - shared state encoding and default width for the sequential divider
package div32_seq_pkg;

    localparam int DIV_N = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_RUN  = RUN,
        ST_DONE = DONE
    } div_state_e;

endpackage

// File: rtl/sub32_gen.sv
// rtl/sub32_gen.sv - parameterised combinational ripple subtractor (a - b, modulo 2^N)
module sub32_gen #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] diff_o
);

    assign diff_o = a_i - b_i;

endmodule

// File: rtl/div32_seq.sv
// rtl/div32_seq.sv - unsigned restoring divider, one quotient bit per clock
module div32_seq
    import div32_seq_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N);

    div_state_e     state_q;
    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   r_q;
    logic [N-1:0]   q_q;
    logic [N-1:0]   d_q;
    logic           busy_q;
    logic           done_q;
    logic [N-1:0]   quotient_q;
    logic [N-1:0]   remainder_q;
    logic           dbz_q;

    logic [N:0]     trial;
    logic [N:0]     diff;
    logic           qbit;
    logic [N-1:0]   r_d;
    logic [N-1:0]   q_d;

    assign trial = {r_q, q_q[N-1]};

    sub32_gen #(.N(N + 1)) u_sub (
        .a_i    (trial),
        .b_i    ({1'b0, d_q}),
        .diff_o (diff)
    );

    // A negative trial difference restores the partial remainder
    assign qbit = ~diff[N];
    assign r_d  = diff[N] ? trial[N-1:0] : diff[N-1:0];
    assign q_d  = {q_q[N-2:0], qbit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        d_q     <= divisor;
                        q_q     <= dividend;
                        r_q     <= '0;
                        cnt_q   <= CW'(N - 1);
                        dbz_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        quotient_q  <= q_d;
                        remainder_q <= r_d;
                        dbz_q       <= (d_q == '0);
                        done_q      <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32_seq.sv
// tb/tb_div32_seq.sv - directed self-checking bench for div32_seq
module tb_div32_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_total = 0;
    int n_bad   = 0;
    int done_cnt = 0;

    div32_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Starts a division and returns how many edges after acceptance done rose.
    // A one-cycle start with other operands is injected inj cycles in (0 = none).
    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          input int inj, output int lat);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            start = 1'b0;
            if (inj != 0 && lat == inj) begin
                start    = 1'b1;
                dividend = 32'd7;
                divisor  = 32'd7;
            end
            if (done) break;
        end
        start = 1'b0;
        if (lat >= 100) check("done_timeout", 32'(lat), 32'd32);
    endtask

    task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input logic edbz);
        int lat;
        do_div(a, b, 0, lat);
        check({tag, "_q"},   quotient,  eq);
        check({tag, "_r"},   remainder, er);
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int dc0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q",    quotient,  32'd0);
        check("rst_r",    remainder, 32'd0);
        check("rst_dbz",  32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 100 / 7 with latency and pulse shape
        dc0 = done_cnt;
        do_div(32'd100, 32'd7, 0, lat);
        check("lat_100_7",  32'(lat), 32'd32);
        check("busy_in_done", 32'(busy), 32'd1);
        check("q_100_7",    quotient,  32'd14);
        check("r_100_7",    remainder, 32'd2);
        check("dbz_100_7",  32'(div_by_zero), 32'd0);
        @(posedge clk);
        #1;
        check("done_fall",  32'(done), 32'd0);
        check("busy_fall",  32'(busy), 32'd0);
        check("npulse_100_7", 32'(done_cnt - dc0), 32'd1);
        check("hold_q",     quotient,  32'd14);

        run_vec("max_1",    32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 32'd0, 1'b0);
        run_vec("max_max",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,          32'd0, 1'b0);
        run_vec("div0",     32'd5,         32'd0,          32'hFFFF_FFFF, 32'd5, 1'b1);
        run_vec("9_3",      32'd9,         32'd3,          32'd3,          32'd0, 1'b0);
        run_vec("3_10",     32'd3,         32'd10,         32'd0,          32'd3, 1'b0);
        run_vec("sign",     32'h8000_0000, 32'h8000_0001, 32'd0, 32'h8000_0000, 1'b0);

        // start re-pulsed mid-run must be ignored
        dc0 = done_cnt;
        do_div(32'd1000, 32'd10, 10, lat);
        check("ign_lat", 32'(lat), 32'd32);
        check("ign_q",   quotient,  32'd100);
        check("ign_r",   remainder, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("ign_npulse", 32'(done_cnt - dc0), 32'd1);
        check("ign_idle",   32'(busy), 32'd0);

        // asynchronous reset in the middle of a run
        @(negedge clk);
        dividend = 32'd1234;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_q",    quotient,  32'd0);
        check("arst_r",    remainder, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_vec("42_5", 32'd42, 32'd5, 32'd8, 32'd2, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
